// File: rtl/stream_pkg.sv
// Shared layout helpers for the credit-based stream arbiter.
// Packets are {valid, leaf, port, payload}; control words are {enable, leaf, port}.
package stream_pkg;

    localparam int CREDIT_RETURN_PORT = 0;
    localparam int CTRL_PORT_LSB      = 0;

    function automatic int ctrl_leaf_lsb(input int port_bits);
        return port_bits;
    endfunction

    function automatic int ctrl_en_bit(input int leaf_bits, input int port_bits);
        return leaf_bits + port_bits;
    endfunction

    function automatic int ctrl_bits(input int leaf_bits, input int port_bits);
        return 1 + leaf_bits + port_bits;
    endfunction

    function automatic int pkt_port_lsb(input int payload_bits);
        return payload_bits;
    endfunction

    function automatic int pkt_leaf_lsb(input int port_bits, input int payload_bits);
        return payload_bits + port_bits;
    endfunction

    function automatic int pkt_valid_bit(input int leaf_bits, input int port_bits,
                                         input int payload_bits);
        return leaf_bits + port_bits + payload_bits;
    endfunction

    function automatic int packet_bits(input int leaf_bits, input int port_bits,
                                       input int payload_bits);
        return 1 + leaf_bits + port_bits + payload_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int  N     = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    logic [N-1:0] req_hi;

    always_comb begin
        req_hi = '0;
        for (int i = 0; i < N; i++) begin
            req_hi[i] = req[i] && (i >= int'(ptr));
        end
    end

    // Lowest request overall is the wrap-around fallback; a request at/after ptr overrides it.
    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) grant_idx = PTR_W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_hi[i]) grant_idx = PTR_W'(i);
        end
        any   = |req;
        grant = any ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/stream_credit_arbiter.sv
// Credit-gated round-robin merge of user channels onto one network stream,
// with network-side resend hold and in-band credit returns.
module stream_credit_arbiter
    import stream_pkg::*;
#(
    parameter int  NUM_LEAF_BITS = 6,
    parameter int  NUM_PORT_BITS = 4,
    parameter int  PAYLOAD_BITS  = 64,
    parameter int  NUM_OUT_PORTS = 7,
    parameter int  CREDIT_BITS   = 8,
    parameter int  CREDIT_INIT   = 64,
    localparam int PACKET_BITS   = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS),
    localparam int CTRL_BITS     = ctrl_bits(NUM_LEAF_BITS, NUM_PORT_BITS)
) (
    input  logic                                  clk_bft,
    input  logic                                  reset,
    input  logic [PACKET_BITS-1:0]                stream_in,
    output logic [PACKET_BITS-1:0]                stream_out,
    input  logic                                  resend,
    input  logic [CTRL_BITS*NUM_OUT_PORTS-1:0]    control_reg,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              ack_interface2user
);

    // Handshake: a user beat moves when vld_user2interface[i] and ack_interface2user[i]
    // are both high in the same cycle; ack is combinational, one-hot or zero, never
    // raised without vld, and vld may be held or dropped freely between beats.

    localparam int PTR_W     = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int VALID_BIT = pkt_valid_bit(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int PORT_LSB  = pkt_port_lsb(PAYLOAD_BITS);
    localparam int LEAF_LSB  = pkt_leaf_lsb(NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int EN_BIT    = ctrl_en_bit(NUM_LEAF_BITS, NUM_PORT_BITS);

    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         grant_idx;
    logic                     grant_any;
    logic [CREDIT_BITS-1:0]   credit      [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_nxt  [NUM_OUT_PORTS];
    logic [CREDIT_BITS:0]     credit_sum  [NUM_OUT_PORTS];
    logic [CTRL_BITS-2:0]     sel_route;
    logic [PAYLOAD_BITS-1:0]  sel_din;

    // Credit return: valid packet addressed to port 0; payload carries {count, channel}.
    logic                     ret_valid;
    logic [NUM_PORT_BITS-1:0] ret_ch;
    logic [CREDIT_BITS-1:0]   ret_n;
    logic                     unused_stream_in;

    assign ret_valid = stream_in[VALID_BIT] &&
                       (stream_in[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CREDIT_RETURN_PORT));
    assign ret_ch    = stream_in[0 +: NUM_PORT_BITS];
    assign ret_n     = stream_in[NUM_PORT_BITS +: CREDIT_BITS];
    assign unused_stream_in = ^{stream_in[LEAF_LSB +: NUM_LEAF_BITS],
                                stream_in[PAYLOAD_BITS-1:NUM_PORT_BITS+CREDIT_BITS]};

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = reset && !resend && vld_user2interface[i] &&
                          control_reg[i*CTRL_BITS + EN_BIT] && (credit[i] != '0);
        end
    end

    rr_arbiter #(.N(NUM_OUT_PORTS)) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign ack_interface2user = grant;

    // One-hot grant lets the route/payload mux be a plain OR-reduction.
    always_comb begin
        sel_route = '0;
        sel_din   = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant[i]) begin
                sel_route = sel_route | control_reg[i*CTRL_BITS +: CTRL_BITS-1];
                sel_din   = sel_din | din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum[i] = {1'b0, credit[i]} - (CREDIT_BITS+1)'(grant[i]) +
                            ((ret_valid && ret_ch == NUM_PORT_BITS'(i)) ? {1'b0, ret_n} : '0);
            credit_nxt[i] = credit_sum[i][CREDIT_BITS] ? '1 : credit_sum[i][CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk_bft) begin
        if (!reset) begin
            stream_out <= '0;
            rr_ptr     <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= CREDIT_BITS'(CREDIT_INIT);
            end
        end else begin
            if (!resend) begin
                stream_out <= grant_any ? {1'b1, sel_route, sel_din} : '0;
            end
            if (grant_any) begin
                rr_ptr <= (grant_idx == PTR_W'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_stream_credit_arbiter.sv
// Directed bench for stream_credit_arbiter: reset, first grant, round-robin order,
// resend hold, ignored returns, saturation and credit exhaustion/refill.
module tb_stream_credit_arbiter;

    localparam int NP     = 7;
    localparam int LB     = 6;
    localparam int PTB    = 4;
    localparam int PAY    = 64;
    localparam int PKT_W  = 1 + LB + PTB + PAY;
    localparam int CTRL_W = 1 + LB + PTB;

    logic                clk_bft = 1'b0;
    logic                reset;
    logic                resend;
    logic [PKT_W-1:0]    stream_in, stream_out, stream_in_s, stream_out_s;
    logic [CTRL_W*NP-1:0] control_reg;
    logic [NP-1:0]       vld, ack, vld_s, ack_s;
    logic [PAY*NP-1:0]   din;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PKT_W-1:0] exp_q[$];

    always #5 clk_bft = ~clk_bft;

    stream_credit_arbiter dut (
        .clk_bft (clk_bft), .reset (reset), .stream_in (stream_in), .stream_out (stream_out),
        .resend (resend), .control_reg (control_reg), .vld_user2interface (vld),
        .din_leaf_user2interface (din), .ack_interface2user (ack)
    );

    stream_credit_arbiter #(.CREDIT_INIT(2)) dut_small (
        .clk_bft (clk_bft), .reset (reset), .stream_in (stream_in_s), .stream_out (stream_out_s),
        .resend (resend), .control_reg (control_reg), .vld_user2interface (vld_s),
        .din_leaf_user2interface (din), .ack_interface2user (ack_s)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    // Channel i routes to leaf i+3, port i+1.
    function automatic logic [CTRL_W-1:0] ctrl_of(input int i, input logic en);
        return {en, 6'(i + 3), 4'(i + 1)};
    endfunction

    function automatic logic [PKT_W-1:0] pkt_of(input int i);
        return {1'b1, 6'(i + 3), 4'(i + 1), din[i*PAY +: PAY]};
    endfunction

    function automatic logic [PKT_W-1:0] ret_pkt(input logic v, input logic [3:0] port,
                                                 input int c, input int n);
        return {v, 6'd0, port, 52'd0, 8'(n), 4'(c)};
    endfunction

    task automatic do_reset();
        reset     = 1'b0;
        vld       = '0;
        resend    = 1'b0;
        stream_in = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Hold vld on one channel and count consecutive acks; bonus credits are
    // returned in the first (granted) cycle.
    task automatic drain(input int ch, input int bonus, output int count);
        count = 0;
        vld   = NP'(1) << ch;
        if (bonus > 0) stream_in = ret_pkt(1'b1, 4'd0, ch, bonus);
        for (int c = 0; c < 400; c++) begin
            #1;
            if (!ack[ch]) break;
            count++;
            tick();
            stream_in = '0;
        end
        stream_in = '0;
        vld       = '0;
        tick();
    endtask

    int cnt;
    int small_exp[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 0};

    initial begin
        reset       = 1'b0;
        resend      = 1'b0;
        stream_in   = '0;
        stream_in_s = '0;
        vld_s       = '0;
        din         = '0;
        for (int i = 0; i < NP; i++) control_reg[i*CTRL_W +: CTRL_W] = ctrl_of(i, 1'b1);

        // Reset: all channels requesting, still nothing acked or sent.
        vld = '1;
        tick();
        check("reset_ack", ack, 0);
        tick();
        check("reset_out", stream_out, 0);
        check("reset_out_small", stream_out_s, 0);
        check("reset_ack_during", ack, 0);

        // First grant: channel 2 only, leaf 5 port 3 payload AB.
        reset = 1'b1;
        din[2*PAY +: PAY] = 64'hAB;
        vld = 7'b0000100;
        #1 check("first_ack", ack, 7'b0000100);
        tick();
        check("first_out", stream_out, {1'b1, 6'd5, 4'd3, 64'hAB});
        vld = '0;
        #1 check("idle_ack", ack, 0);
        tick();
        check("idle_out", stream_out, 0);

        // Round robin with every channel requesting.
        do_reset();
        for (int i = 0; i < NP; i++) din[i*PAY +: PAY] = 64'h100 + 64'(i);
        vld = '1;
        for (int k = 0; k < 8; k++) begin
            #1 check("rr_ack", ack, NP'(1) << (k % NP));
            exp_q.push_back(pkt_of(k % NP));
            tick();
            check("rr_out", stream_out, exp_q.pop_front());
        end

        // Resend holds the last packet, freezes grants and the pointer.
        #1 check("pre_resend_ack", ack, NP'(1) << 1);
        tick();
        check("pre_resend_out", stream_out, pkt_of(1));
        resend = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check("resend_ack", ack, 0);
            tick();
            check("resend_out", stream_out, pkt_of(1));
        end
        resend = 1'b0;
        #1 check("post_resend_ack2", ack, NP'(1) << 2);
        tick();
        check("post_resend_out2", stream_out, pkt_of(2));
        #1 check("post_resend_ack3", ack, NP'(1) << 3);
        tick();
        check("post_resend_out3", stream_out, pkt_of(3));

        // Reset mid-stream discards the held packet.
        reset = 1'b0;
        #1 check("midreset_ack", ack, 0);
        tick();
        check("midreset_out", stream_out, 0);
        reset = 1'b1;
        vld   = '0;
        tick();
        check("post_reset_out", stream_out, 0);

        // Disabled channel with vld, plus an out-of-range return (c=9).
        control_reg[4*CTRL_W +: CTRL_W] = ctrl_of(4, 1'b0);
        vld       = 7'b0010000;
        stream_in = ret_pkt(1'b1, 4'd0, 9, 5);
        for (int k = 0; k < 2; k++) begin
            #1 check("disabled_ack", ack, 0);
            tick();
            check("disabled_out", stream_out, 0);
        end
        stream_in = '0;
        control_reg[4*CTRL_W +: CTRL_W] = ctrl_of(4, 1'b1);
        #1 check("reenabled_ack", ack, NP'(1) << 4);
        tick();
        check("reenabled_out", stream_out, pkt_of(4));
        vld = '0;
        tick();

        // Returns with valid=0 or a nonzero port are ignored.
        stream_in = ret_pkt(1'b0, 4'd0, 6, 5);
        tick();
        stream_in = ret_pkt(1'b1, 4'd2, 6, 5);
        tick();
        stream_in = '0;
        drain(6, 0, cnt);
        check("ignored_returns_ch6", cnt, 64);
        drain(1, 0, cnt);
        check("out_of_range_ch1", cnt, 64);

        // Saturation at 255, then grant+return(1) in the same cycle keeps 255.
        stream_in = ret_pkt(1'b1, 4'd0, 5, 191);
        tick();
        stream_in = ret_pkt(1'b1, 4'd0, 5, 10);
        tick();
        stream_in = '0;
        drain(5, 1, cnt);
        check("saturate_ch5", cnt, 256);

        // Small instance: two credits, exhaustion, refill of three.
        vld_s = 7'b0000001;
        for (int k = 0; k < 9; k++) begin
            stream_in_s = (k == 4) ? ret_pkt(1'b1, 4'd0, 0, 3) : '0;
            #1 check("small_ack", ack_s, NP'(small_exp[k]));
            tick();
            if (small_exp[k] == 1) check("small_out", stream_out_s, pkt_of(0));
        end
        vld_s       = '0;
        stream_in_s = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_credit_arbiter.md
STREAM_CREDIT_ARBITER -- requirements
Module: stream_credit_arbiter

Interface
REQ-001 SHALL have parameter NUM_LEAF_BITS, default 6, width of the destination leaf field.
REQ-002 SHALL have parameter NUM_PORT_BITS, default 4, width of the destination port field.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 64, user payload width.
REQ-004 SHALL have parameter NUM_OUT_PORTS, default 7, number of user output channels; legal range 1 to 2^NUM_PORT_BITS-1.
REQ-005 SHALL have parameter CREDIT_BITS, default 8, credit counter width.
REQ-006 SHALL have parameter CREDIT_INIT, default 64, credits per channel after reset; legal range 0 to 2^CREDIT_BITS-1.
REQ-007 SHALL derive localparams PACKET_BITS = 1+NUM_LEAF_BITS+NUM_PORT_BITS+PAYLOAD_BITS, CTRL_BITS = 1+NUM_LEAF_BITS+NUM_PORT_BITS.
REQ-008 SHALL use one clock and a synchronous, active-low reset: clk_bft (input, 1) and reset (input, 1, active-low, synchronous to clk_bft).
REQ-009 Ports: stream_in, input, PACKET_BITS, packet from network; stream_out, output, PACKET_BITS, packet to network.
REQ-010 Ports: resend, input, 1, network requests repeat of the current stream_out.
REQ-011 Ports: control_reg, input, CTRL_BITS*NUM_OUT_PORTS; channel i at [i*CTRL_BITS +: CTRL_BITS] = {enable, dest_leaf, dest_port} MSB to LSB.
REQ-012 Ports: vld_user2interface, input, NUM_OUT_PORTS; din_leaf_user2interface, input, PAYLOAD_BITS*NUM_OUT_PORTS, channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]; ack_interface2user, output, NUM_OUT_PORTS.

Function
REQ-013 Packet layout SHALL be {valid, leaf, port, payload}, MSB to LSB; valid=0 denotes an idle slot.
REQ-014 Channel i SHALL be eligible in a cycle iff vld_i=1, enable_i=1, credit_i>0 and resend=0.
REQ-015 At most one channel SHALL be granted per cycle, round-robin: first eligible index scanning cyclically from rr_ptr; after a grant, rr_ptr = (grant+1) mod NUM_OUT_PORTS; otherwise rr_ptr unchanged.
REQ-016 ack_interface2user SHALL be combinational, one-hot or zero, high only for the granted channel; transfer occurs when vld and ack are both high.
REQ-017 A grant in cycle t SHALL produce stream_out at t+1 = {1, dest_leaf_i, dest_port_i, din_i}, using control_reg sampled at t; latency exactly 1 cycle.
REQ-018 With no grant and resend=0 in cycle t, stream_out SHALL be all-zero at t+1.
REQ-019 With resend=1 in cycle t, stream_out SHALL hold its value at t+1, with no grant and no ack; consecutive resend cycles hold indefinitely.
REQ-020 A grant of channel i SHALL decrement credit_i by 1 at t+1.
REQ-021 A stream_in packet with valid=1 and port field=0 is a credit return: payload[NUM_PORT_BITS-1:0] = channel index c, payload[NUM_PORT_BITS +: CREDIT_BITS] = count n; credit_c SHALL increase by n at t+1.
REQ-022 Credit returns with c >= NUM_OUT_PORTS, or with valid=0 or port field!=0, SHALL be ignored.
REQ-023 A simultaneous grant and return on the same channel SHALL yield credit = old-1+n, computed in CREDIT_BITS+1 bits and saturated at 2^CREDIT_BITS-1.
REQ-024 A channel with credit 0 SHALL never be acked; a disabled channel SHALL never be acked, and its credits are retained.

Reset
REQ-025 While reset=0 at a clk_bft edge: stream_out=0, every credit=CREDIT_INIT, rr_ptr=0.
REQ-026 ack_interface2user SHALL be 0 throughout reset; a reset asserted mid-stream discards the held packet, so the first post-reset stream_out is idle.

Structure
REQ-027 Package stream_pkg SHALL hold the packet field offset and width functions, the credit-return port constant 0, and CTRL_BITS layout offsets.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_arbiter (parameter N; inputs req, ptr; outputs grant one-hot, grant_idx, any).
REQ-029 Credit counters, rr_ptr and the stream_out register SHALL reside in stream_credit_arbiter.

Verification
REQ-030 Reset with CREDIT_INIT=64 -> stream_out=0, acks 0; first vld on channel 2 (leaf 5, port 3, payload 0xAB) -> ack_2 in the same cycle, stream_out={1,5,3,0xAB} next cycle.
REQ-031 All 7 channels hold vld=1 continuously -> acks 0,1,...,6,0 in successive cycles, no gaps.
REQ-032 CREDIT_INIT=2, channel 0 only -> two packets sent, then ack_0 stays 0; credit return {port 0, c=0, n=3} -> three further packets.
REQ-033 resend=1 for 3 cycles during traffic -> stream_out is repeated 3 extra cycles, no acks, rr_ptr unchanged, and traffic resumes in order afterwards.
REQ-034 Credit at 255 plus a return of n=10 -> saturates at 255; grant plus return n=1 in the same cycle -> credit unchanged.
REQ-035 Return with c=9 (NUM_OUT_PORTS=7) and disabled channel with vld=1 -> no credit change and no ack.
